// File: rtl/elevator_pkg.sv
// Shared elevator types and helpers: dispatcher state encoding, floor-index
// conversion and "any call above/below" mask queries.
package elevator_pkg;

  localparam int DEF_NUM_FLOORS = 3;
  localparam int DEF_FLOOR_W    = 2;
  localparam int MAX_FLOORS     = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR      = 3'd3,
    FAULT     = 3'd4
  } state_t;

  function automatic int onehot_to_index(input logic [MAX_FLOORS-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic is_multi_hot(input logic [MAX_FLOORS-1:0] v);
    return (v & (v - {{(MAX_FLOORS-1){1'b0}}, 1'b1})) != '0;
  endfunction

  function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask, input int floor);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i > floor && mask[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask, input int floor);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i < floor && mask[i]) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/travel_watchdog.sv
// Travel watchdog: counts cycles while enabled, reloads on clear, and flags
// expiry once the count reaches the timeout (count saturates there).
module travel_watchdog #(
  parameter logic [31:0] TIMEOUT = 32'd500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != TIMEOUT) begin
      count <= count + 32'd1;
    end
  end

  assign expired = (count == TIMEOUT);

endmodule

// File: rtl/call_dispatch.sv
// Elevator call dispatcher: latches calls, tracks the car floor, runs the SCAN
// motion FSM with door requests and a travel watchdog. Optional: CALL_CANCEL_EN.
module call_dispatch
  import elevator_pkg::*;
#(
  parameter int          NUM_FLOORS     = DEF_NUM_FLOORS,
  parameter int          FLOOR_W        = DEF_FLOOR_W,
  parameter logic [31:0] TRAVEL_TIMEOUT = 32'd500000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [NUM_FLOORS-1:0] floor_hit,
  input  logic                  door_done,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  fault,
  output state_t                dbg_state
);

  state_t                state;
  logic                  dir_up;
  logic                  moving;
  logic                  hit_any;
  logic                  hit_multi;
  int                    hit_idx;
  logic [FLOOR_W-1:0]    hit_floor;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] pend_nxt;
  logic                  wd_expired;
  logic                  fault_trip;
  logic                  serve_hit;
  logic                  serve_idle;
  logic                  ahead;
  logic                  at_end;

  assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
  assign hit_any   = |floor_hit;
  assign hit_multi = is_multi_hot(MAX_FLOORS'(floor_hit));
  assign hit_idx   = onehot_to_index(MAX_FLOORS'(floor_hit));
  assign hit_floor = FLOOR_W'(hit_idx);
  assign cur_mask  = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << cur_floor;
  assign dbg_state = state;

  travel_watchdog #(.TIMEOUT(TRAVEL_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (!moving || hit_any),
    .enable  (moving),
    .expired (wd_expired)
  );

  // Service clears always win over a same-cycle call for that floor.
  always_comb begin
    fault_trip = (state != FAULT) && (hit_multi || wd_expired);
    serve_hit  = moving && hit_any && !fault_trip && ((floor_hit & pending) != '0);
    serve_idle = (state == IDLE) && !fault_trip && ((pending & cur_mask) != '0);
    clr_mask   = '0;
    if (serve_hit)  clr_mask = floor_hit;
    if (serve_idle) clr_mask = cur_mask;
    set_mask = call_req & ((state == DOOR) ? ~cur_mask : {NUM_FLOORS{1'b1}});
`ifdef CALL_CANCEL_EN
    begin
      logic [NUM_FLOORS-1:0] protect_mask;
      logic [NUM_FLOORS-1:0] cancel_mask;
      protect_mask = '0;
      if (state == MOVE_UP)   protect_mask = (cur_mask << 1) & pending;
      if (state == MOVE_DOWN) protect_mask = (cur_mask >> 1) & pending;
      cancel_mask = set_mask & pending & ~protect_mask;
      pend_nxt    = ((pending | set_mask) & ~cancel_mask) & ~clr_mask;
    end
`else
    pend_nxt = (pending | set_mask) & ~clr_mask;
`endif
    ahead  = (state == MOVE_UP) ? any_above(MAX_FLOORS'(pend_nxt), hit_idx)
                                : any_below(MAX_FLOORS'(pend_nxt), hit_idx);
    at_end = (state == MOVE_UP) ? (hit_idx == NUM_FLOORS - 1) : (hit_idx == 0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      dir_up     <= 1'b1;
      pending    <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_open  <= 1'b0;
      cur_floor  <= '0;
      fault      <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (hit_any && !hit_multi) cur_floor <= hit_floor;
      if (fault_trip) begin
        state      <= FAULT;
        motor_up   <= 1'b0;
        motor_down <= 1'b0;
        door_open  <= 1'b0;
        fault      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (serve_idle) begin
              state     <= DOOR;
              door_open <= 1'b1;
            end else if (dir_up && any_above(MAX_FLOORS'(pending), int'(cur_floor))) begin
              state    <= MOVE_UP;
              motor_up <= 1'b1;
            end else if (!dir_up && any_below(MAX_FLOORS'(pending), int'(cur_floor))) begin
              state      <= MOVE_DOWN;
              motor_down <= 1'b1;
            end else if (any_above(MAX_FLOORS'(pending), int'(cur_floor))) begin
              state    <= MOVE_UP;
              motor_up <= 1'b1;
              dir_up   <= 1'b1;
            end else if (any_below(MAX_FLOORS'(pending), int'(cur_floor))) begin
              state      <= MOVE_DOWN;
              motor_down <= 1'b1;
              dir_up     <= 1'b0;
            end
          end
          MOVE_UP, MOVE_DOWN: begin
            if (hit_any) begin
              if (serve_hit) begin
                state      <= DOOR;
                motor_up   <= 1'b0;
                motor_down <= 1'b0;
                door_open  <= 1'b1;
              end else if (!ahead || at_end) begin
                state      <= IDLE;
                motor_up   <= 1'b0;
                motor_down <= 1'b0;
              end
            end
          end
          DOOR: begin
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            if (door_done) begin
              door_open <= 1'b0;
              state     <= IDLE;
            end
          end
          FAULT: begin
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            door_open  <= 1'b0;
            fault      <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_call_dispatch.sv
// Directed bench for call_dispatch (3 floors, short travel timeout).
module tb_call_dispatch;
  import elevator_pkg::*;

  localparam int N = 3;

  logic         clk;
  logic         rstn;
  logic [N-1:0] call_req;
  logic [N-1:0] floor_hit;
  logic         door_done;
  logic [N-1:0] pending;
  logic         motor_up;
  logic         motor_down;
  logic         door_open;
  logic [1:0]   cur_floor;
  logic         fault;
  state_t       dbg_state;

  int n_cmp;
  int n_err;

  call_dispatch #(.NUM_FLOORS(N), .FLOOR_W(2), .TRAVEL_TIMEOUT(32'd40)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .call_req   (call_req),
    .floor_hit  (floor_hit),
    .door_done  (door_done),
    .pending    (pending),
    .motor_up   (motor_up),
    .motor_down (motor_down),
    .door_open  (door_open),
    .cur_floor  (cur_floor),
    .fault      (fault),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; call_req = '0; floor_hit = '0; door_done = 1'b0;
    repeat (2) cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic pulse_call(input logic [N-1:0] v);
    call_req = v; cyc(); call_req = '0;
  endtask

  task automatic pulse_hit(input logic [N-1:0] v);
    floor_hit = v; cyc(); floor_hit = '0;
  endtask

  task automatic pulse_done();
    door_done = 1'b1; cyc(); door_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({pending, motor_up, motor_down, door_open, cur_floor, fault} !== 9'b0) begin
      $display("FAIL reset_outputs: got %b required 000000000",
               {pending, motor_up, motor_down, door_open, cur_floor, fault});
      n_err++;
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE); n_err++;
    end
  endtask

  task automatic test_serve_up();
    pulse_call(3'b100);
    n_cmp++;
    if (pending !== 3'b100 || motor_up !== 1'b0) begin
      $display("FAIL call_latch: pending=%b up=%b required 100/0", pending, motor_up); n_err++;
    end
    cyc();
    n_cmp++;
    if (motor_up !== 1'b1 || motor_down !== 1'b0) begin
      $display("FAIL start_up: up=%b down=%b required 1/0", motor_up, motor_down); n_err++;
    end
    pulse_hit(3'b010);
    n_cmp++;
    if (motor_up !== 1'b1 || cur_floor !== 2'd1) begin
      $display("FAIL pass_floor1: up=%b floor=%0d required 1/1", motor_up, cur_floor); n_err++;
    end
    pulse_hit(3'b100);
    n_cmp++;
    if ({motor_up, door_open, pending, cur_floor} !== {1'b0, 1'b1, 3'b000, 2'd2}) begin
      $display("FAIL arrive_floor2: up=%b door=%b pending=%b floor=%0d required 0/1/000/2",
               motor_up, door_open, pending, cur_floor);
      n_err++;
    end
  endtask

  task automatic test_reverse_down();
    int ups;
    pulse_call(3'b100);
    n_cmp++;
    if (pending !== 3'b000 || door_open !== 1'b1) begin
      $display("FAIL door_absorb: pending=%b door=%b required 000/1", pending, door_open); n_err++;
    end
    ups = 0;
    pulse_done();
    if (motor_up) ups++;
    n_cmp++;
    if (door_open !== 1'b0) begin
      $display("FAIL door_release: door=%b required 0", door_open); n_err++;
    end
    pulse_call(3'b001);
    if (motor_up) ups++;
    cyc();
    if (motor_up) ups++;
    n_cmp++;
    if (motor_down !== 1'b1 || ups !== 0) begin
      $display("FAIL start_down: down=%b up_cycles=%0d required 1/0", motor_down, ups); n_err++;
    end
    pulse_hit(3'b010);
    pulse_hit(3'b001);
    n_cmp++;
    if ({motor_down, door_open, pending, cur_floor} !== {1'b0, 1'b1, 3'b000, 2'd0}) begin
      $display("FAIL arrive_floor0: down=%b door=%b pending=%b floor=%0d required 0/1/000/0",
               motor_down, door_open, pending, cur_floor);
      n_err++;
    end
    pulse_done();
  endtask

  task automatic test_scan_order();
    pulse_call(3'b100);
    cyc();
    pulse_hit(3'b010);
    pulse_call(3'b001);
    n_cmp++;
    if (pending !== 3'b101 || motor_up !== 1'b1) begin
      $display("FAIL scan_pending: pending=%b up=%b required 101/1", pending, motor_up); n_err++;
    end
    pulse_hit(3'b100);
    n_cmp++;
    if ({door_open, pending, cur_floor, motor_down} !== {1'b1, 3'b001, 2'd2, 1'b0}) begin
      $display("FAIL scan_first_stop: door=%b pending=%b floor=%0d down=%b required 1/001/2/0",
               door_open, pending, cur_floor, motor_down);
      n_err++;
    end
    pulse_done();
    cyc();
    n_cmp++;
    if (motor_down !== 1'b1 || motor_up !== 1'b0) begin
      $display("FAIL scan_reverse: down=%b up=%b required 1/0", motor_down, motor_up); n_err++;
    end
    pulse_hit(3'b010);
    // Arrival at floor 0 with a same-cycle call for floors 0 and 1.
    call_req = 3'b011; floor_hit = 3'b001; cyc(); call_req = '0; floor_hit = '0;
    n_cmp++;
    if (pending !== 3'b010 || door_open !== 1'b1 || cur_floor !== 2'd0) begin
      $display("FAIL clear_wins: pending=%b door=%b floor=%0d required 010/1/0",
               pending, door_open, cur_floor);
      n_err++;
    end
    pulse_done();
    cyc();
    n_cmp++;
    if (motor_up !== 1'b1 || motor_down !== 1'b0) begin
      $display("FAIL up_after_reverse: up=%b down=%b required 1/0", motor_up, motor_down); n_err++;
    end
    pulse_hit(3'b010);
    n_cmp++;
    if (door_open !== 1'b1 || pending !== 3'b000 || cur_floor !== 2'd1) begin
      $display("FAIL mid_stop: door=%b pending=%b floor=%0d required 1/000/1",
               door_open, pending, cur_floor);
      n_err++;
    end
    pulse_done();
  endtask

  task automatic test_watchdog();
    int waited;
    do_reset();
    pulse_call(3'b100);
    cyc();
    repeat (30) cyc();
    pulse_hit(3'b010);
    repeat (30) cyc();
    n_cmp++;
    if (fault !== 1'b0 || motor_up !== 1'b1) begin
      $display("FAIL wd_reload: fault=%b up=%b required 0/1", fault, motor_up); n_err++;
    end
    waited = 0;
    while (fault !== 1'b1 && waited < 60) begin
      cyc();
      waited++;
    end
    n_cmp++;
    if ({fault, motor_up, motor_down, door_open} !== 4'b1000 || dbg_state !== FAULT) begin
      $display("FAIL wd_trip: fault/up/down/door=%b state=%0d after %0d cycles required 1000/%0d",
               {fault, motor_up, motor_down, door_open}, dbg_state, waited, FAULT);
      n_err++;
    end
    pulse_call(3'b001);
    pulse_done();
    pulse_hit(3'b001);
    repeat (10) cyc();
    n_cmp++;
    if ({fault, motor_up, motor_down, door_open} !== 4'b1000) begin
      $display("FAIL fault_sticky: fault/up/down/door=%b required 1000",
               {fault, motor_up, motor_down, door_open});
      n_err++;
    end
    do_reset();
    n_cmp++;
    if (fault !== 1'b0 || dbg_state !== IDLE) begin
      $display("FAIL fault_clear: fault=%b state=%0d required 0/%0d", fault, dbg_state, IDLE);
      n_err++;
    end
  endtask

  task automatic test_sensor_and_async_reset();
    pulse_hit(3'b100);
    n_cmp++;
    if (cur_floor !== 2'd2 || dbg_state !== IDLE || motor_up !== 1'b0) begin
      $display("FAIL idle_hit: floor=%0d state=%0d up=%b required 2/%0d/0",
               cur_floor, dbg_state, motor_up, IDLE);
      n_err++;
    end
    pulse_hit(3'b011);
    n_cmp++;
    if (fault !== 1'b1 || dbg_state !== FAULT) begin
      $display("FAIL multi_hot: fault=%b state=%0d required 1/%0d", fault, dbg_state, FAULT);
      n_err++;
    end
    do_reset();
    pulse_call(3'b100);
    cyc();
    n_cmp++;
    if (motor_up !== 1'b1) begin
      $display("FAIL pre_reset_up: up=%b required 1", motor_up); n_err++;
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (motor_up !== 1'b0 || door_open !== 1'b0 || pending !== 3'b000) begin
      $display("FAIL async_reset: up=%b door=%b pending=%b required 0/0/000",
               motor_up, door_open, pending);
      n_err++;
    end
    do_reset();
  endtask

  task automatic test_repeat_press();
    do_reset();
    pulse_hit(3'b100);
    pulse_call(3'b001);
    pulse_call(3'b001);
    n_cmp++;
    if (pending !== 3'b001 || motor_down !== 1'b1) begin
      $display("FAIL repeat_press: pending=%b down=%b required 001/1", pending, motor_down);
      n_err++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0; call_req = '0; floor_hit = '0; door_done = 1'b0;
    test_reset();
    test_serve_up();
    test_reverse_down();
    test_scan_order();
    test_watchdog();
    test_sensor_and_async_reset();
    test_repeat_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
